// File: rtl/fp_vec_add_seq.sv
// fp_vec_add_seq
//   Sequencer between the 32-entry operand RAM and the combinational
//   single-precision adder. On start it streams len element pairs out of
//   RAM, presents each pair to the adder and writes each sum back, one
//   element at a time. Sticky flags report overflow and negative operands.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   start             : job request, honoured only in IDLE
//   src_a, src_b, dst : base addresses of operand A, operand B and result
//   len               : element count (0 is legal)
//   busy, done        : job running / one-cycle completion pulse
//   ovf, sgn          : sticky exponent-FF result / negative-operand flags
//   mem_*             : RAM port (mode 0: write via addr_a, read via addr_b)
//   add_a, add_b      : adder operands
//   add_y             : adder sum (combinational)
module fp_vec_add_seq #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned LEN_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic              sgn,
  output logic              mem_mode,
  output logic [ADDR_W-1:0] mem_addr_a,
  output logic [ADDR_W-1:0] mem_addr_b,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       add_a,
  output logic [31:0]       add_b,
  input  logic [31:0]       add_y
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_CAP_B,
    S_EXEC,
    S_WR,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next_state;

  logic [ADDR_W-1:0]   r_src_a;
  logic [ADDR_W-1:0]   r_src_b;
  logic [ADDR_W-1:0]   r_dst;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_i;
  logic [31:0]         r_op_a;
  logic [31:0]         r_op_b;
  logic [31:0]         r_res;
  logic                r_ovf;
  logic                r_sgn;

  logic [LEN_W-1:0]    w_i_next;
  logic                w_last;
  logic [ADDR_W-1:0]   w_i_addr;

  assign w_i_next = r_i + LEN_W'(1);
  assign w_last   = (w_i_next == r_len);
  // Index folded to address width; the add below discards the carry so
  // addresses wrap around the RAM.
  assign w_i_addr = ADDR_W'(r_i);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = (len == '0) ? S_DONE : S_RD_A;
      S_RD_A:  w_next_state = S_RD_B;
      S_RD_B:  w_next_state = S_CAP_B;
      S_CAP_B: w_next_state = S_EXEC;
      S_EXEC:  w_next_state = S_WR;
      S_WR:    w_next_state = w_last ? S_DONE : S_RD_A;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // RAM / adder / status outputs, decoded from the registered state only
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    mem_we     = 1'b0;
    mem_addr_a = '0;
    mem_addr_b = '0;
    mem_wdata  = '0;
    add_a      = '0;
    add_b      = '0;
    case (r_state)
      S_RD_A: begin
        busy       = 1'b1;
        mem_addr_b = r_src_a + w_i_addr;
      end
      S_RD_B: begin
        busy       = 1'b1;
        mem_addr_b = r_src_b + w_i_addr;
      end
      S_CAP_B: begin
        busy = 1'b1;
      end
      S_EXEC: begin
        busy  = 1'b1;
        add_a = r_op_a;
        add_b = r_op_b;
      end
      S_WR: begin
        busy       = 1'b1;
        mem_we     = 1'b1;
        mem_addr_a = r_dst + w_i_addr;
        mem_wdata  = r_res;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_mode = 1'b0;
  assign ovf      = r_ovf;
  assign sgn      = r_sgn;

  // Job parameters, operand/result registers and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_src_a <= '0;
      r_src_b <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_i     <= '0;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_res   <= '0;
      r_ovf   <= 1'b0;
      r_sgn   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_src_a <= src_a;
            r_src_b <= src_b;
            r_dst   <= dst;
            r_len   <= len;
            r_i     <= '0;
            r_ovf   <= 1'b0;
            r_sgn   <= 1'b0;
          end
        end
        S_RD_B: begin
          r_op_a <= mem_rdata;
        end
        S_CAP_B: begin
          r_op_b <= mem_rdata;
          if (r_op_a[31] || mem_rdata[31]) r_sgn <= 1'b1;
        end
        S_EXEC: begin
          r_res <= add_y;
        end
        S_WR: begin
          if (r_res[30:23] == 8'hFF) r_ovf <= 1'b1;
          r_i <= w_i_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_vec_add_seq.sv
module tb_fp_vec_add_seq;

  localparam int AW = 5;
  localparam int LW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] src_a, src_b, dst;
  logic [LW-1:0] len;
  logic          busy, done, ovf, sgn, mem_mode, mem_we;
  logic [AW-1:0] mem_addr_a, mem_addr_b;
  logic [31:0]   mem_wdata, mem_rdata, add_a, add_b, add_y;

  // RAM backdoor used by the bench to preload words while the DUT is idle
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [31:0]   bd_data;

  logic [31:0]   ram     [32];
  logic [31:0]   ref_mem [32];
  logic [31:0]   exp_a   [64];
  logic [31:0]   exp_b   [64];
  logic [31:0]   exp_r   [64];
  logic          exp_ovf, exp_sgn;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_vec_add_seq #(.ADDR_W(AW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .src_a(src_a), .src_b(src_b), .dst(dst), .len(len),
    .busy(busy), .done(done), .ovf(ovf), .sgn(sgn),
    .mem_mode(mem_mode), .mem_addr_a(mem_addr_a), .mem_addr_b(mem_addr_b),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .add_a(add_a), .add_b(add_b), .add_y(add_y)
  );

  // Registered-read RAM, mode 0: write through addr_a, read through addr_b
  always @(posedge clk) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (mem_we) ram[mem_addr_a] <= mem_wdata;
    mem_rdata <= ram[mem_addr_b];
  end

  // Positive-only single-precision adder (sign ignored, truncating)
  function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] hi, lo;
    logic [7:0]  e;
    logic [24:0] mh, ml, s;
    int unsigned d;
    if (x[30:23] >= y[30:23]) begin hi = x; lo = y; end
    else begin hi = y; lo = x; end
    if (hi[30:23] == 8'hFF) return {1'b0, 8'hFF, 23'd0};
    if (hi[30:23] == 8'h00) return 32'd0;
    if (lo[30:23] == 8'h00) return {1'b0, hi[30:0]};
    e  = hi[30:23];
    d  = 32'(hi[30:23]) - 32'(lo[30:23]);
    mh = {2'b01, hi[22:0]};
    ml = {2'b01, lo[22:0]};
    ml = (d > 24) ? 25'd0 : (ml >> d);
    s  = mh + ml;
    if (s[24]) begin
      s = s >> 1;
      e = e + 8'd1;
    end
    if (e == 8'hFF) return {1'b0, 8'hFF, 23'd0};
    return {1'b0, e, s[22:0]};
  endfunction

  assign add_y = fp_add(add_a, add_b);

  task automatic load_word(input logic [AW-1:0] a, input logic [31:0] v);
    bd_addr = a;
    bd_data = v;
    bd_we   = 1'b1;
    @(posedge clk); #1;
    bd_we   = 1'b0;
    ref_mem[a] = v;
  endtask

  // Element-by-element reference: each result is stored before the next
  // element is read, so overlapping source/destination behaves as in place.
  task automatic model_job(input logic [AW-1:0] sa, input logic [AW-1:0] sb,
                           input logic [AW-1:0] dd, input int n);
    logic [AW-1:0] aa, ab, ad;
    exp_ovf = 1'b0;
    exp_sgn = 1'b0;
    for (int k = 0; k < n; k++) begin
      aa = sa + AW'(k);
      ab = sb + AW'(k);
      ad = dd + AW'(k);
      exp_a[k] = ref_mem[aa];
      exp_b[k] = ref_mem[ab];
      exp_r[k] = fp_add(exp_a[k], exp_b[k]);
      ref_mem[ad] = exp_r[k];
      if (exp_a[k][31] || exp_b[k][31]) exp_sgn = 1'b1;
      if (exp_r[k][30:23] == 8'hFF) exp_ovf = 1'b1;
    end
  endtask

  // Must be entered at #1 into a cycle where the DUT is IDLE; returns at #1
  // into the IDLE cycle right after DONE, so consecutive calls are
  // back-to-back at minimum spacing.
  task automatic run_job(input logic [AW-1:0] sa, input logic [AW-1:0] sb,
                         input logic [AW-1:0] dd, input logic [LW-1:0] n_in,
                         input int spur);
    int n;
    int ph, k;
    logic [109:0] obs, expv;
    logic [AW-1:0] e_aa, e_ab;
    logic [31:0]   e_wd, e_xa, e_xb;
    logic          e_we;
    n = int'(n_in);
    model_job(sa, sb, dd, n);
    src_a = sa; src_b = sb; dst = dd; len = n_in; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    src_a = AW'($urandom); src_b = AW'($urandom);
    dst   = AW'($urandom); len   = LW'($urandom);
    for (int c = 1; c <= 5 * n + 1; c++) begin
      start = (c == spur);
      e_aa = '0; e_ab = '0; e_wd = '0; e_xa = '0; e_xb = '0; e_we = 1'b0;
      if (c <= 5 * n) begin
        ph = (c - 1) % 5;
        k  = (c - 1) / 5;
        case (ph)
          0: e_ab = sa + AW'(k);
          1: e_ab = sb + AW'(k);
          3: begin e_xa = exp_a[k]; e_xb = exp_b[k]; end
          4: begin e_we = 1'b1; e_aa = dd + AW'(k); e_wd = exp_r[k]; end
          default: ;
        endcase
      end
      expv = {(c <= 5 * n), (c == 5 * n + 1), 1'b0, e_we, e_aa, e_ab, e_wd, e_xa, e_xb};
      obs  = {busy, done, mem_mode, mem_we, mem_addr_a, mem_addr_b, mem_wdata, add_a, add_b};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL cycle%0d_outputs len=%0d got %h want %h", c, n, obs, expv);
      end
      if (c == 1) begin
        checks++;
        if ({ovf, sgn} !== 2'b00) begin
          errors++;
          $display("FAIL flags_cleared_on_start got ovf=%b sgn=%b want 0 0", ovf, sgn);
        end
      end
      if (c == 5 * n + 1) begin
        checks++;
        if ({ovf, sgn} !== {exp_ovf, exp_sgn}) begin
          errors++;
          $display("FAIL job_flags got ovf=%b sgn=%b want ovf=%b sgn=%b", ovf, sgn, exp_ovf, exp_sgn);
        end
      end
      if (c < 5 * n + 1) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if ({busy, done, mem_we} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_done got busy=%b done=%b we=%b want 0 0 0", busy, done, mem_we);
    end
    for (int j = 0; j < 32; j++) begin
      checks++;
      if (ram[j] !== ref_mem[j]) begin
        errors++;
        $display("FAIL mem[%0d] got %h want %h", j, ram[j], ref_mem[j]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    src_a = '0; src_b = '0; dst = '0; len = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({busy, done, ovf, sgn, mem_mode, mem_we, mem_addr_a, mem_addr_b,
         mem_wdata, add_a, add_b} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b ovf=%b sgn=%b we=%b aa=%h ab=%h wd=%h xa=%h xb=%h want all 0",
               busy, done, ovf, sgn, mem_we, mem_addr_a, mem_addr_b, mem_wdata, add_a, add_b);
    end
    for (int j = 0; j < 32; j++)
      load_word(AW'(j), {1'b0, 8'(100 + j), 23'($urandom)});
  endtask

  task automatic test_single();
    load_word(5'd0, 32'h41D00000);
    load_word(5'd1, 32'h42700000);
    run_job(5'd0, 5'd1, 5'd2, 6'd1, 0);
    checks++;
    if (ram[2] !== 32'h42AC0000) begin
      errors++;
      $display("FAIL single_sum got %h want 42ac0000", ram[2]);
    end
  endtask

  task automatic test_wrap();
    load_word(5'd30, 32'h3F800000); load_word(5'd31, 32'h3F800000);
    load_word(5'd0,  32'h3F800000); load_word(5'd4,  32'h3F800000);
    load_word(5'd5,  32'h3F800000); load_word(5'd6,  32'h3F800000);
    run_job(5'd30, 5'd4, 5'd10, 6'd3, 0);
    for (int j = 10; j < 13; j++) begin
      checks++;
      if (ram[j] !== 32'h40000000) begin
        errors++;
        $display("FAIL wrap_sum[%0d] got %h want 40000000", j, ram[j]);
      end
    end
  endtask

  task automatic test_zero_len();
    run_job(5'd7, 5'd8, 5'd9, 6'd0, 0);
  endtask

  task automatic test_overflow();
    load_word(5'd0, 32'h7F000000);
    load_word(5'd1, 32'h7F000000);
    run_job(5'd0, 5'd1, 5'd2, 6'd1, 0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ram[2] !== 32'h7F800000 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL overflow got mem=%h ovf=%b want 7f800000 1", ram[2], ovf);
    end
    // next start clears ovf; run_job verifies the cleared flags in cycle 1
    load_word(5'd0, 32'h3F800000);
    load_word(5'd1, 32'h3F800000);
    run_job(5'd0, 5'd1, 5'd2, 6'd1, 0);
  endtask

  task automatic test_in_place();
    load_word(5'd3, 32'h40400000);
    load_word(5'd7, 32'h3F800000);
    run_job(5'd3, 5'd7, 5'd3, 6'd1, 0);
    checks++;
    if (ram[3] !== 32'h40800000 || sgn !== 1'b0) begin
      errors++;
      $display("FAIL in_place got mem=%h sgn=%b want 40800000 0", ram[3], sgn);
    end
    load_word(5'd3, 32'h40400000);
    load_word(5'd7, 32'hBF800000);
    run_job(5'd3, 5'd7, 5'd3, 6'd1, 0);
    checks++;
    if (sgn !== 1'b1) begin
      errors++;
      $display("FAIL sign_flag got %b want 1", sgn);
    end
  endtask

  task automatic test_reset_mid_job();
    load_word(5'd20, 32'hC0000000);
    load_word(5'd21, 32'h3F800000);
    load_word(5'd22, 32'h3F800000);
    load_word(5'd23, 32'h40000000);
    load_word(5'd25, 32'h12345678);
    load_word(5'd26, 32'h0ABCDEF0);
    src_a = 5'd20; src_b = 5'd22; dst = 5'd25; len = 6'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (add_a !== 32'hC0000000 || sgn !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_exec got add_a=%h sgn=%b want c0000000 1", add_a, sgn);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({busy, mem_we, done, ovf, sgn} !== 5'b00000) begin
      errors++;
      $display("FAIL post_reset got busy=%b we=%b done=%b ovf=%b sgn=%b want 0", busy, mem_we, done, ovf, sgn);
    end
    for (int c = 0; c < 6; c++) begin
      checks++;
      if ({busy, mem_we, done} !== 3'b000) begin
        errors++;
        $display("FAIL post_reset_idle%0d got busy=%b we=%b done=%b want 0 0 0", c, busy, mem_we, done);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (ram[25] !== 32'h12345678 || ram[26] !== 32'h0ABCDEF0) begin
      errors++;
      $display("FAIL aborted_dst got %h %h want 12345678 0abcdef0", ram[25], ram[26]);
    end
    run_job(5'd20, 5'd22, 5'd25, 6'd2, 0);
  endtask

  task automatic test_ignored_start();
    run_job(5'd12, 5'd16, 5'd24, 6'd3, 8);
    run_job(5'd12, 5'd16, 5'd24, 6'd3, 16);
  endtask

  task automatic test_back_to_back();
    run_job(5'd1, 5'd2, 5'd3, 6'd2, 0);
    run_job(5'd3, 5'd4, 5'd1, 6'd2, 0);
    run_job(5'd28, 5'd29, 5'd30, 6'd4, 0);
  endtask

  task automatic test_random();
    logic [AW-1:0] sa, sb, dd;
    logic [LW-1:0] n;
    logic [7:0]    e;
    for (int it = 0; it < 14; it++) begin
      for (int w = 0; w < 6; w++) begin
        e = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(250, 254))
                                        : 8'($urandom_range(100, 140));
        load_word(AW'($urandom), {($urandom_range(0, 7) == 0), e, 23'($urandom)});
      end
      sa = AW'($urandom);
      sb = AW'($urandom);
      dd = AW'($urandom);
      n  = LW'($urandom_range(0, 7));
      run_job(sa, sb, dd, n, int'($urandom_range(0, 5 * int'(n) + 1)));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_zero_len();
    test_overflow();
    test_in_place();
    test_reset_mid_job();
    test_ignored_start();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_vec_add_seq.md
# fp_vec_add_seq

Sequencer between the 32-entry operand RAM and the combinational single-precision adder. On `start` it streams `len` element pairs out of RAM, presents each pair to the adder, and writes every sum back to RAM. It raises sticky status flags and pulses `done` when the job ends. The RAM-side and adder-side ports connect directly to the existing RAM and adder blocks without glue logic.

## Interface
- `ADDR_W`, 5: RAM address width. Addresses wrap modulo 2^ADDR_W.
- `LEN_W`, 6: width of the element-count input.
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: job request. Sampled only in IDLE.
- `src_a`, `src_b`, `dst` in ADDR_W: base addresses of operand A, operand B and the result.
- `len` in LEN_W: number of elements. 0 is legal.
- `busy` out 1: high while a job runs (RD_A through the final WR).
- `done` out 1: one-cycle pulse at job end.
- `ovf` out 1: sticky; set if any written result has exponent 8'hFF.
- `sgn` out 1: sticky; set if any operand read has bit 31 set. The adder handles only positive operands.
- `mem_mode` out 1: RAM mode select. Held 0 (write to address_a, read from address_b).
- `mem_addr_a` out ADDR_W: RAM write address.
- `mem_addr_b` out ADDR_W: RAM read address.
- `mem_we` out 1: RAM write enable.
- `mem_wdata` out 32: RAM write data.
- `mem_rdata` in 32: RAM registered read data. Valid the cycle after the address is presented.
- `add_a`, `add_b` out 32: adder operands.
- `add_y` in 32: adder sum (combinational).

## Operation
- **States:** IDLE, RD_A, RD_B, CAP_B, EXEC, WR, DONE. The state register, index `i` (LEN_W), and registers `op_a`, `op_b`, `res` are all cleared by `rst`.
- **IDLE:** `start`=1 captures `src_a`, `src_b`, `dst`, `len`, and clears `i`, `ovf`, `sgn`.
  - Goes to DONE if `len`==0, else RD_A.
- **RD_A:** `mem_we`=0, `mem_addr_b` = `src_a`+`i`.
- **RD_B:** `op_a` <= `mem_rdata`; `mem_addr_b` = `src_b`+`i`.
- **CAP_B:** `op_b` <= `mem_rdata`.
  - `sgn` is set if `op_a[31]` or `mem_rdata[31]`.
- **EXEC:** `add_a`=`op_a`, `add_b`=`op_b`; `res` <= `add_y`.
- **WR:** `mem_we`=1, `mem_addr_a` = `dst`+`i`, `mem_wdata` = `res`.
  - `ovf` is set if `res[30:23]`==8'hFF.
  - Then `i`<=`i`+1, and the FSM goes to DONE if `i`+1==`len`, else RD_A.
- **DONE:** `done`=1, `busy`=0; next state IDLE.
- **Output decoding:** RAM and adder outputs are decoded from registered state. Outside the states listed above, `mem_we`=0, and `mem_addr_a`, `mem_addr_b`, `mem_wdata`, `add_a`, `add_b` are 0.
- **Address arithmetic:** ADDR_W bits, carry discarded, so address 31+1 wraps to 0.
- **Ordering:** strictly element by element. Element `i` is written before element `i`+1 is read, so in-place operation (`dst`==`src_a` or `dst`==`src_b`) is correct.
- **Ignored `start`:** `start` is ignored in every state except IDLE, including DONE.
- **Reset mid-job:** `rst` in any state returns the FSM to IDLE on that edge. In the next cycle `mem_we`=0, `busy`=0, `done`=0 and flags are 0. A pending WR is aborted, and no partial write occurs after the reset edge.

## Timing
- **Reset values:** every output is 0.
- **Cycle numbering:** cycle 0 is the edge where `start` is sampled.
  - Element k occupies cycles 5k+1 (RD_A) through 5k+5 (WR).
  - `done` is high in cycle 5·`len`+1.
  - For `len`=0, `done` is high in cycle 1.
- **`busy`:** high in cycles 1 through 5·`len`.
- **Back-to-back jobs:** minimum spacing is `start` accepted in the cycle after DONE (the IDLE cycle).
- **Read latency:** RAM read latency is exactly 1 cycle. RD_A, RD_B and CAP_B rely on it.
- **Adder path:** `add_y` must settle within EXEC. It is registered into `res`, so the adder is never in the RAM write path.

## Test plan
- **Single element:** mem[0]=0x41D00000 (26.0), mem[1]=0x42700000 (60.0); `src_a`=0, `src_b`=1, `dst`=2, `len`=1.
  - mem[2]=0x42AC0000 (86.0).
  - `done` pulses in cycle 6; `ovf`=0, `sgn`=0; `mem_we` is high only in cycle 5.
- **Vector with wrap:** `src_a`=30, `src_b`=4, `dst`=10, `len`=3; mem[30,31,0] and mem[4,5,6] each hold 0x3F800000 (1.0).
  - mem[10..12]=0x40000000 (2.0).
  - Read addresses are 30, 31, 0; `done` pulses in cycle 16.
- **Zero length and overflow:** `len`=0 -> `done` pulses in cycle 1, `busy` never asserts, `mem_we` never asserts.
  - Separately, operands 0x7F000000 + 0x7F000000 -> written 0x7F800000, `ovf`=1 until the next `start`.
- **In-place and sign:** `dst`=`src_a`=3, mem[3]=0x40400000 (3.0), mem[7]=0x3F800000 (1.0) -> mem[3]=0x40800000 (4.0).
  - Rerun with mem[7]=0xBF800000 -> `sgn`=1.
- **Reset mid-job and ignored start:** `len`=2; assert `rst` for one edge during element 0 EXEC.
  - Next cycle `busy`=0 and `mem_we`=0; the destination word is unchanged.
  - A fresh `start` then completes normally.
  - A `start` pulsed during a running job changes nothing: same results, same `done` cycle.
